instr_fetch_stage: RTL

- Consumer end of the instruction-address interface.
- Accepts the next-instruction pstate pair (pstate0 = status/segment word, pstate1 = instruction offset) from the instruction address stage.
- Issues a single-outstanding request/acknowledge fetch to the instruction cache, then presents the fetched instruction word and its pstate pair to the decode stage under a valid/stall handshake.
- Handles pipeline flush (redirect), fetch-error traps and misaligned-address traps.

---
 rtl/instr_fetch_stage.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_stage.sv
// ---------------------------------------------------------------------------
// instr_fetch_stage
//
// Purpose:
//   Fetch stage sitting between the instruction address stage and decode.
//   It accepts a (pstate0, pstate1) pair, sends one request at a time to the
//   instruction cache and hands the returned word plus its pstate pair to
//   decode under a valid/stall handshake. It also handles pipeline flushes,
//   fetch-error traps and misaligned-offset traps.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   inPstate0/1, inAdrValid       next address pair from the address stage
//   outAdrReady                   address accepted this cycle (combinational)
//   inFlush                       kill the in-flight fetch and held instruction
//   outIcReq, outIcPs0/1          cache request and its address pair
//   inIcAck, inIcData, inIcErr    cache response (inIcErr qualified by ack)
//   outValid, inStall             decode handshake
//   outInstr, outPstate0/1        instruction word and its pstate pair
//   outTrapCode                   0 none, 1 misaligned, 2 fetch error
//
// States:
//   state | meaning
//   IDLE  | no fetch in flight, nothing held for decode, ready for an address
//   REQ   | cache request outstanding, waiting for ack
//   DRAIN | flushed while a request was outstanding; waiting for ack to drop it
//   OUT   | instruction (or trap) presented to decode
// ---------------------------------------------------------------------------
module instr_fetch_stage #(
    parameter int WORD_LENGTH = 32,
    parameter int ALIGN_BITS  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_LENGTH-1:0] inPstate0,
    input  logic [WORD_LENGTH-1:0] inPstate1,
    input  logic                   inAdrValid,
    output logic                   outAdrReady,
    input  logic                   inFlush,
    output logic                   outIcReq,
    output logic [WORD_LENGTH-1:0] outIcPs0,
    output logic [WORD_LENGTH-1:0] outIcPs1,
    input  logic                   inIcAck,
    input  logic [WORD_LENGTH-1:0] inIcData,
    input  logic                   inIcErr,
    output logic                   outValid,
    input  logic                   inStall,
    output logic [WORD_LENGTH-1:0] outInstr,
    output logic [WORD_LENGTH-1:0] outPstate0,
    output logic [WORD_LENGTH-1:0] outPstate1,
    output logic [1:0]             outTrapCode
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    localparam logic [1:0] TRAP_NONE      = 2'd0;
    localparam logic [1:0] TRAP_MISALIGN  = 2'd1;
    localparam logic [1:0] TRAP_FETCH_ERR = 2'd2;

    logic [1:0]             r_state;
    logic                   r_ic_req;
    logic [WORD_LENGTH-1:0] r_ic_ps0;
    logic [WORD_LENGTH-1:0] r_ic_ps1;
    logic                   r_valid;
    logic [WORD_LENGTH-1:0] r_instr;
    logic [WORD_LENGTH-1:0] r_pstate0;
    logic [WORD_LENGTH-1:0] r_pstate1;
    logic [1:0]             r_trap;

    logic [1:0]             w_state_nxt;
    logic                   w_ic_req_nxt;
    logic [WORD_LENGTH-1:0] w_ic_ps0_nxt;
    logic [WORD_LENGTH-1:0] w_ic_ps1_nxt;
    logic                   w_valid_nxt;
    logic [WORD_LENGTH-1:0] w_instr_nxt;
    logic [WORD_LENGTH-1:0] w_pstate0_nxt;
    logic [WORD_LENGTH-1:0] w_pstate1_nxt;
    logic [1:0]             w_trap_nxt;

    logic                   w_adr_ready;
    logic                   w_accept;
    logic                   w_misaligned;

    // OUT can take a new address only in the cycle decode consumes the
    // current instruction, which gives the overlapped handoff.
    assign w_adr_ready  = !inFlush &&
                          ((r_state == ST_IDLE) || ((r_state == ST_OUT) && !inStall));
    assign w_accept     = inAdrValid && w_adr_ready;
    assign w_misaligned = (inPstate1[ALIGN_BITS-1:0] != '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_ic_req_nxt  = r_ic_req;
        w_ic_ps0_nxt  = r_ic_ps0;
        w_ic_ps1_nxt  = r_ic_ps1;
        w_valid_nxt   = r_valid;
        w_instr_nxt   = r_instr;
        w_pstate0_nxt = r_pstate0;
        w_pstate1_nxt = r_pstate1;
        w_trap_nxt    = r_trap;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_misaligned) begin
                        // Trap goes straight to decode; the cache never sees it.
                        w_valid_nxt   = 1'b1;
                        w_trap_nxt    = TRAP_MISALIGN;
                        w_instr_nxt   = '0;
                        w_pstate0_nxt = inPstate0;
                        w_pstate1_nxt = inPstate1;
                        w_state_nxt   = ST_OUT;
                    end else begin
                        w_ic_req_nxt  = 1'b1;
                        w_ic_ps0_nxt  = inPstate0;
                        w_ic_ps1_nxt  = inPstate1;
                        w_state_nxt   = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                if (inIcAck && !inFlush) begin
                    w_ic_req_nxt  = 1'b0;
                    w_valid_nxt   = 1'b1;
                    w_instr_nxt   = inIcData;
                    w_pstate0_nxt = r_ic_ps0;
                    w_pstate1_nxt = r_ic_ps1;
                    w_trap_nxt    = inIcErr ? TRAP_FETCH_ERR : TRAP_NONE;
                    w_state_nxt   = ST_OUT;
                end else if (inIcAck) begin
                    w_ic_req_nxt  = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end else if (inFlush) begin
                    // Request stays up until the cache answers; its data is dropped.
                    w_state_nxt   = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (inIcAck) begin
                    w_ic_req_nxt  = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end
            end

            ST_OUT: begin
                if (inFlush) begin
                    w_valid_nxt   = 1'b0;
                    w_trap_nxt    = TRAP_NONE;
                    w_state_nxt   = ST_IDLE;
                end else if (!inStall) begin
                    if (w_accept && w_misaligned) begin
                        w_valid_nxt   = 1'b1;
                        w_trap_nxt    = TRAP_MISALIGN;
                        w_instr_nxt   = '0;
                        w_pstate0_nxt = inPstate0;
                        w_pstate1_nxt = inPstate1;
                        w_state_nxt   = ST_OUT;
                    end else if (w_accept) begin
                        w_valid_nxt   = 1'b0;
                        w_trap_nxt    = TRAP_NONE;
                        w_ic_req_nxt  = 1'b1;
                        w_ic_ps0_nxt  = inPstate0;
                        w_ic_ps1_nxt  = inPstate1;
                        w_state_nxt   = ST_REQ;
                    end else begin
                        w_valid_nxt   = 1'b0;
                        w_trap_nxt    = TRAP_NONE;
                        w_state_nxt   = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_ic_req_nxt = 1'b0;
                w_valid_nxt  = 1'b0;
                w_trap_nxt   = TRAP_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ic_req  <= 1'b0;
            r_ic_ps0  <= '0;
            r_ic_ps1  <= '0;
            r_valid   <= 1'b0;
            r_instr   <= '0;
            r_pstate0 <= '0;
            r_pstate1 <= '0;
            r_trap    <= TRAP_NONE;
        end else begin
            r_state   <= w_state_nxt;
            r_ic_req  <= w_ic_req_nxt;
            r_ic_ps0  <= w_ic_ps0_nxt;
            r_ic_ps1  <= w_ic_ps1_nxt;
            r_valid   <= w_valid_nxt;
            r_instr   <= w_instr_nxt;
            r_pstate0 <= w_pstate0_nxt;
            r_pstate1 <= w_pstate1_nxt;
            r_trap    <= w_trap_nxt;
        end
    end

    assign outAdrReady = w_adr_ready;
    assign outIcReq    = r_ic_req;
    assign outIcPs0    = r_ic_ps0;
    assign outIcPs1    = r_ic_ps1;
    assign outValid    = r_valid;
    assign outInstr    = r_instr;
    assign outPstate0  = r_pstate0;
    assign outPstate1  = r_pstate1;
    assign outTrapCode = r_trap;

endmodule
